amiq_dcr_slave_regs: RTL and testbench



---
 rtl/amiq_dcr_slave_regs.sv | 157 +++++++++++++++
 tb/tb_amiq_dcr_slave_regs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amiq_dcr_slave_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | amiq_dcr_slave_regs : DCR target with a register bank and programmable     |
// |   acknowledge delay. Optional AMIQ_DCR_SLAVE_ERR_CNT_EN adds err_cnt.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module amiq_dcr_slave_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h100,
  parameter int          NUM_REGS  = 8,
  parameter int          ACK_DELAY = 2,
  parameter logic [15:0] PRIV_MASK = 16'h0000,
  parameter logic [31:0] REG_RST   = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   read,
  input  logic                   write,
  input  logic                   privileged,
  input  logic [3:0]             master_id,
  input  logic [31:0]            a_bus,
  input  logic [31:0]            d_bus_out,
  output logic                   ack,
  output logic                   timeout_wait,
  output logic [31:0]            d_bus_in,
  output logic [NUM_REGS*32-1:0] reg_q,
  output logic                   priv_err,
  output logic [3:0]             last_master_id
`ifdef AMIQ_DCR_SLAVE_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_is_wr;
  logic             r_priv;
  logic [3:0]       r_mid;
  logic [31:0]      r_regs [NUM_REGS];

  logic [31:0]      w_off;
  logic             w_hit, w_latch, w_ack_entry, w_abort, w_viol;
  logic [IDX_W-1:0] w_x_idx;
  logic             w_x_wr, w_x_priv;
  logic [3:0]       w_x_mid;

  // w_off < NUM_REGS only matters once a_bus >= BASE_ADDR, so no underflow
  assign w_off   = a_bus - BASE_ADDR;
  assign w_hit   = (a_bus >= BASE_ADDR) && (w_off < 32'(NUM_REGS));
  assign w_latch = (r_state == S_IDLE) && (read ^ write) && w_hit && !ack;

  // With zero delay the ack entry coincides with the latch edge, so use live inputs
  assign w_x_idx  = (r_state == S_IDLE) ? w_off[IDX_W-1:0] : r_idx;
  assign w_x_wr   = (r_state == S_IDLE) ? write            : r_is_wr;
  assign w_x_priv = (r_state == S_IDLE) ? privileged       : r_priv;
  assign w_x_mid  = (r_state == S_IDLE) ? master_id        : r_mid;
  assign w_viol   = PRIV_MASK[4'(w_x_idx)] && !w_x_priv;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_entry = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_latch) begin
          if (ACK_DELAY == 0) begin
            w_state_nxt = S_ACK;
            w_ack_entry = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(ACK_DELAY - 1);
          end
        end
      end
      S_WAIT: begin
        if (!read && !write) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACK;
          w_ack_entry = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACK:   if (!read && !write) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_idx          <= '0;
      r_is_wr        <= 1'b0;
      r_priv         <= 1'b0;
      r_mid          <= 4'd0;
      ack            <= 1'b0;
      timeout_wait   <= 1'b0;
      d_bus_in       <= 32'h0;
      priv_err       <= 1'b0;
      last_master_id <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      priv_err     <= 1'b0;
      timeout_wait <= (w_state_nxt == S_WAIT);
      if (w_latch) begin
        r_idx   <= w_off[IDX_W-1:0];
        r_is_wr <= write;
        r_priv  <= privileged;
        r_mid   <= master_id;
      end
      if (w_ack_entry) begin
        ack            <= 1'b1;
        last_master_id <= w_x_mid;
        priv_err       <= w_viol;
        d_bus_in       <= (!w_x_wr && !w_viol) ? r_regs[w_x_idx] : 32'h0;
      end else if (w_state_nxt != S_ACK) begin
        ack      <= 1'b0;
        d_bus_in <= 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_RST;
    end else if (w_ack_entry && w_x_wr && !w_viol) begin
      r_regs[w_x_idx] <= d_bus_out;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign reg_q[32*i +: 32] = r_regs[i];
  end

`ifdef AMIQ_DCR_SLAVE_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= 8'd0;
    end else if ((w_abort || (w_ack_entry && w_viol)) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_amiq_dcr_slave_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_amiq_dcr_slave_regs : scoreboard bench for the DCR slave register block |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_amiq_dcr_slave_regs;

  localparam logic [31:0] RST_V = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n, read, write, privileged, sel4;
  logic [3:0]  master_id;
  logic [31:0] a_bus, d_bus_out;
  logic        rd_m, wr_m, rd_4, wr_4;

  logic        ack, timeout_wait, priv_err;
  logic [31:0] d_bus_in;
  logic [255:0] reg_q;
  logic [3:0]  last_master_id;
  logic        ack4, tw4, perr4;
  logic [31:0] dbi4;
  logic [255:0] reg_q4;
  logic [3:0]  lmid4;
`ifdef AMIQ_DCR_SLAVE_ERR_CNT_EN
  logic [7:0]  err_cnt, err_cnt4;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mdl [8];
  logic [32:0] sb_q [$];

  always #5 clk = ~clk;

  assign rd_m = read  & ~sel4;
  assign wr_m = write & ~sel4;
  assign rd_4 = read  &  sel4;
  assign wr_4 = write &  sel4;

  amiq_dcr_slave_regs #(
    .BASE_ADDR(32'h100), .NUM_REGS(8), .ACK_DELAY(2),
    .PRIV_MASK(16'h0001), .REG_RST(RST_V)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .read(rd_m), .write(wr_m),
    .privileged(privileged), .master_id(master_id), .a_bus(a_bus),
    .d_bus_out(d_bus_out), .ack(ack), .timeout_wait(timeout_wait),
    .d_bus_in(d_bus_in), .reg_q(reg_q), .priv_err(priv_err),
    .last_master_id(last_master_id)
`ifdef AMIQ_DCR_SLAVE_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  amiq_dcr_slave_regs #(
    .BASE_ADDR(32'h100), .NUM_REGS(8), .ACK_DELAY(4),
    .PRIV_MASK(16'h0001), .REG_RST(RST_V)
  ) u_d4 (
    .clk(clk), .reset_n(reset_n), .read(rd_4), .write(wr_4),
    .privileged(privileged), .master_id(master_id), .a_bus(a_bus),
    .d_bus_out(d_bus_out), .ack(ack4), .timeout_wait(tw4),
    .d_bus_in(dbi4), .reg_q(reg_q4), .priv_err(perr4),
    .last_master_id(lmid4)
`ifdef AMIQ_DCR_SLAVE_ERR_CNT_EN
    , .err_cnt(err_cnt4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (reg_q[32*i +: 32] !== mdl[i]) begin
        n_err++;
        $display("FAIL %s reg%0d: got %h want %h", name, i, reg_q[32*i +: 32], mdl[i]);
      end
    end
  endtask

  // Full handshake on the ACK_DELAY=2 instance, checked against the model
  task automatic do_xfer(input bit is_wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit priv, input logic [3:0] mid);
    int          idx = int'(addr - 32'h100);
    bit          viol = (idx == 0) && !priv;
    int          n = 0;
    int          ntw = 0;
    logic [32:0] exp;
    sb_q.push_back({viol, (is_wr || viol) ? 32'h0 : mdl[idx]});
    if (is_wr && !viol) mdl[idx] = data;
    a_bus = addr; d_bus_out = data; privileged = priv; master_id = mid;
    read = !is_wr; write = is_wr;
    do begin
      step();
      n++;
      if (timeout_wait) ntw++;
    end while (!ack && n < 20);
    exp = sb_q.pop_front();
    n_vec += 5;
    if (n !== 3) begin n_err++; $display("FAIL latency @%h: got %0d want 3", addr, n); end
    if (ntw !== 2) begin n_err++; $display("FAIL tw_cycles @%h: got %0d want 2", addr, ntw); end
    if (d_bus_in !== exp[31:0]) begin
      n_err++; $display("FAIL rdata @%h: got %h want %h", addr, d_bus_in, exp[31:0]);
    end
    if (priv_err !== exp[32]) begin
      n_err++; $display("FAIL priv_err @%h: got %b want %b", addr, priv_err, exp[32]);
    end
    if (last_master_id !== mid) begin
      n_err++; $display("FAIL last_mid @%h: got %0d want %0d", addr, last_master_id, mid);
    end
    step();
    n_vec++;
    if (ack !== 1'b1 || d_bus_in !== exp[31:0] || priv_err !== 1'b0) begin
      n_err++;
      $display("FAIL hold @%h: ack %b data %h perr %b want 1 %h 0", addr, ack, d_bus_in, priv_err, exp[31:0]);
    end
    read = 1'b0; write = 1'b0;
    step();
    n_vec++;
    if (ack !== 1'b0 || d_bus_in !== 32'h0) begin
      n_err++; $display("FAIL ack_fall @%h: ack %b data %h want 0 0", addr, ack, d_bus_in);
    end
    step();
  endtask

  // Holds a command that must be ignored, watching for any response
  task automatic hold_ignored(input string name, input bit rd, input bit wr, input logic [31:0] addr);
    bit bad = 1'b0;
    a_bus = addr; d_bus_out = 32'hFFFF_FFFF; privileged = 1'b1; master_id = 4'd9;
    read = rd; write = wr;
    repeat (6) begin
      step();
      if (ack !== 1'b0 || timeout_wait !== 1'b0 || d_bus_in !== 32'h0) bad = 1'b1;
    end
    read = 1'b0; write = 1'b0;
    step();
    n_vec++;
    if (bad) begin n_err++; $display("FAIL %s: got a response, want none", name); end
    check_regs(name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read = 1'b0; write = 1'b0; sel4 = 1'b0; privileged = 1'b0;
    master_id = 4'd0; a_bus = 32'h0; d_bus_out = 32'h0;
    for (int i = 0; i < 8; i++) mdl[i] = RST_V;
    repeat (3) step();
    n_vec++;
    if ({ack, timeout_wait, priv_err, d_bus_in, last_master_id} !== 39'h0) begin
      n_err++;
      $display("FAIL reset_outs: ack %b tw %b perr %b data %h mid %0d want all 0",
               ack, timeout_wait, priv_err, d_bus_in, last_master_id);
    end
    check_regs("reset_regs");
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    do_xfer(1'b1, 32'h102, 32'hCAFE_0001, 1'b1, 4'd3);
    n_vec++;
    if (reg_q[95:64] !== 32'hCAFE_0001) begin
      n_err++; $display("FAIL reg2_write: got %h want cafe0001", reg_q[95:64]);
    end
    do_xfer(1'b0, 32'h102, 32'h0, 1'b1, 4'd5);
  endtask

  task automatic test_miss();
    hold_ignored("miss_0ff", 1'b1, 1'b0, 32'h0FF);
    hold_ignored("miss_108", 1'b1, 1'b0, 32'h108);
    hold_ignored("miss_wr_108", 1'b0, 1'b1, 32'h108);
    hold_ignored("rd_and_wr", 1'b1, 1'b1, 32'h101);
  endtask

  task automatic test_priv();
    do_xfer(1'b1, 32'h100, 32'h0000_1234, 1'b0, 4'd7);
    check_regs("priv_wr_drop");
    do_xfer(1'b0, 32'h100, 32'h0, 1'b0, 4'd7);
    do_xfer(1'b0, 32'h100, 32'h0, 1'b1, 4'd8);
`ifdef AMIQ_DCR_SLAVE_ERR_CNT_EN
    n_vec++;
    if (err_cnt !== 8'd2) begin n_err++; $display("FAIL err_cnt_priv: got %0d want 2", err_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 8; i++) do_xfer(1'b1, 32'h100 + 32'(i), $urandom, 1'b0, 4'(i));
    check_regs("b2b_regs");
    for (int i = 7; i >= 0; i--) do_xfer(1'b0, 32'h100 + 32'(i), 32'h0, 1'b1, 4'(15 - i));
  endtask

  task automatic test_abort();
    int  n = 0;
    bool_loop: begin end
    sel4 = 1'b1;
    a_bus = 32'h101; d_bus_out = 32'hDEAD_BEEF; privileged = 1'b1; master_id = 4'd2;
    write = 1'b1;
    step();
    n_vec++;
    if (tw4 !== 1'b1) begin n_err++; $display("FAIL abort_tw_on: got %b want 1", tw4); end
    write = 1'b0;
    step();
    n_vec++;
    if (tw4 !== 1'b0 || ack4 !== 1'b0) begin
      n_err++; $display("FAIL abort_tw_off: tw %b ack %b want 0 0", tw4, ack4);
    end
    repeat (6) begin
      step();
      if (ack4 !== 1'b0) n++;
    end
    n_vec += 2;
    if (n != 0) begin n_err++; $display("FAIL abort_no_ack: ack seen %0d cycles want 0", n); end
    if (reg_q4[63:32] !== RST_V) begin
      n_err++; $display("FAIL abort_no_commit: got %h want %h", reg_q4[63:32], RST_V);
    end
`ifdef AMIQ_DCR_SLAVE_ERR_CNT_EN
    n_vec++;
    if (err_cnt4 !== 8'd1) begin n_err++; $display("FAIL err_cnt_abort: got %0d want 1", err_cnt4); end
`endif
    read = 1'b1;
    n = 0;
    do begin step(); n++; end while (!ack4 && n < 20);
    n_vec++;
    if (n !== 5 || dbi4 !== RST_V) begin
      n_err++; $display("FAIL abort_then_read: latency %0d data %h want 5 %h", n, dbi4, RST_V);
    end
    read = 1'b0;
    repeat (2) step();
    sel4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    a_bus = 32'h103; d_bus_out = 32'h7777_0003; privileged = 1'b1; master_id = 4'd4;
    write = 1'b1;
    step();
    n_vec++;
    if (timeout_wait !== 1'b1) begin n_err++; $display("FAIL rst_wait_pre: tw %b want 1", timeout_wait); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (ack !== 1'b0 || timeout_wait !== 1'b0) begin
      n_err++; $display("FAIL rst_in_wait: ack %b tw %b want 0 0", ack, timeout_wait);
    end
    write = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = RST_V;
    step();
    check_regs("rst_wait_regs");
    do_xfer(1'b1, 32'h105, 32'h1357_9BDF, 1'b1, 4'd6);
    a_bus = 32'h101; privileged = 1'b1; read = 1'b1;
    do begin step(); n++; end while (!ack && n < 20);
    n_vec++;
    if (ack !== 1'b1 || d_bus_in !== RST_V) begin
      n_err++; $display("FAIL rst_ack_pre: ack %b data %h want 1 %h", ack, d_bus_in, RST_V);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (ack !== 1'b0 || timeout_wait !== 1'b0 || d_bus_in !== 32'h0) begin
      n_err++; $display("FAIL rst_in_ack: ack %b tw %b data %h want 0 0 0", ack, timeout_wait, d_bus_in);
    end
    read = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = RST_V;
    step();
    check_regs("rst_ack_regs");
`ifdef AMIQ_DCR_SLAVE_ERR_CNT_EN
    n_vec++;
    if (err_cnt !== 8'd0) begin n_err++; $display("FAIL err_cnt_rst: got %0d want 0", err_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_miss();
    test_priv();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    n_vec++;
    if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d entries want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
